// File: rtl/micro_sequencer.sv
// micro_sequencer: decodes the microinstruction sequencing field into micro address counter commands.
// Define MICRO_SEQUENCER_STACK_GUARD_EN to trap return-stack overflow/underflow in a FAULT state.
module micro_sequencer #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int STACK_DEPTH   = 4,
    parameter int WAIT_TIMEOUT  = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    // `sequence` is a reserved word in SystemVerilog, hence the suffix.
    input  logic [2:0]               sequence_op,
    input  logic [ADDRESS_WIDTH-1:0] target,
    input  logic                     condition,
    input  logic [ADDRESS_WIDTH-1:0] dispatchAddress,
    input  logic                     ready,
    input  logic [ADDRESS_WIDTH-1:0] address,
    output logic [1:0]               command,
    output logic [ADDRESS_WIDTH-1:0] loadAddress,
    output logic                     timedOut,
    output logic                     stackOverflow,
    output logic                     stackUnderflow,
    output logic                     faulted
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
`ifdef MICRO_SEQUENCER_STACK_GUARD_EN
    // One extra bit so the pointer can hold the full occupancy 0..STACK_DEPTH.
    localparam int PTR_W = IDX_W + 1;
    localparam logic [1:0] ST_FAULT = 2'd2;
`else
    localparam int PTR_W = IDX_W;
`endif
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_WAITING = 2'd1;

    localparam logic [2:0] OP_NEXT     = 3'd0;
    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_BRANCH   = 3'd2;
    localparam logic [2:0] OP_CALL     = 3'd3;
    localparam logic [2:0] OP_RETURN   = 3'd4;
    localparam logic [2:0] OP_DISPATCH = 3'd5;
    localparam logic [2:0] OP_WAIT     = 3'd6;
    localparam logic [2:0] OP_FETCH    = 3'd7;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_INC   = 2'd1;
    localparam logic [1:0] CMD_RESET = 2'd2;
    localparam logic [1:0] CMD_LOAD  = 2'd3;

    localparam logic [7:0] TIMEOUT = 8'(WAIT_TIMEOUT);

    logic [1:0]               state, state_next;
    logic [7:0]               wait_count, count_next;
    logic [PTR_W-1:0]         ptr, ptr_next;
    logic [ADDRESS_WIDTH-1:0] stack [STACK_DEPTH];
    logic                     push;
    logic [IDX_W-1:0]         push_idx, pop_idx;
    logic [ADDRESS_WIDTH-1:0] push_data, top;

    // Index arithmetic wraps modulo STACK_DEPTH, which also yields the unguarded overwrite/underflow reads.
    assign push_idx  = ptr[IDX_W-1:0];
    assign pop_idx   = push_idx - 1'b1;
    assign top       = stack[pop_idx];
    assign push_data = address + 1'b1;

`ifdef MICRO_SEQUENCER_STACK_GUARD_EN
    logic full, empty, set_overflow, set_underflow;
    assign full  = (ptr == PTR_W'(STACK_DEPTH));
    assign empty = (ptr == '0);
`endif

    always_comb begin
        // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
        state_next  = state;
        count_next  = wait_count;
        ptr_next    = ptr;
        push        = 1'b0;
        command     = CMD_NONE;
        loadAddress = '0;
        timedOut    = 1'b0;
`ifdef MICRO_SEQUENCER_STACK_GUARD_EN
        set_overflow  = 1'b0;
        set_underflow = 1'b0;
`endif
        case (state)
            ST_RUN: begin
                case (sequence_op)
                    OP_NEXT: command = CMD_INC;
                    OP_JUMP: begin
                        command     = CMD_LOAD;
                        loadAddress = target;
                    end
                    OP_BRANCH: begin
                        if (condition) begin
                            command     = CMD_LOAD;
                            loadAddress = target;
                        end else begin
                            command = CMD_INC;
                        end
                    end
                    OP_CALL: begin
`ifdef MICRO_SEQUENCER_STACK_GUARD_EN
                        if (full) begin
                            set_overflow = 1'b1;
                            state_next   = ST_FAULT;
                        end else
`endif
                        begin
                            push        = 1'b1;
                            ptr_next    = ptr + 1'b1;
                            command     = CMD_LOAD;
                            loadAddress = target;
                        end
                    end
                    OP_RETURN: begin
`ifdef MICRO_SEQUENCER_STACK_GUARD_EN
                        if (empty) begin
                            set_underflow = 1'b1;
                            state_next    = ST_FAULT;
                        end else
`endif
                        begin
                            ptr_next    = ptr - 1'b1;
                            command     = CMD_LOAD;
                            loadAddress = top;
                        end
                    end
                    OP_DISPATCH: begin
                        command     = CMD_LOAD;
                        loadAddress = dispatchAddress;
                    end
                    OP_WAIT: begin
                        if (ready) begin
                            command = CMD_INC;
                        end else begin
                            count_next = 8'd1;
                            state_next = ST_WAITING;
                        end
                    end
                    OP_FETCH: begin
                        command  = CMD_RESET;
                        ptr_next = '0;
                    end
                endcase
            end
            ST_WAITING: begin
                if (ready) begin
                    command    = CMD_INC;
                    state_next = ST_RUN;
                end else if (wait_count == TIMEOUT) begin
                    command     = CMD_LOAD;
                    loadAddress = target;
                    timedOut    = 1'b1;
                    state_next  = ST_RUN;
                end else begin
                    count_next = wait_count + 8'd1;
                end
            end
            default: ;
        endcase
        // The counter is held in reset alongside us, whatever the decode says.
        if (reset) begin
            command     = CMD_RESET;
            loadAddress = '0;
            timedOut    = 1'b0;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            wait_count <= '0;
            ptr        <= '0;
        end else begin
            state      <= state_next;
            wait_count <= count_next;
            ptr        <= ptr_next;
        end
    end

    // NOTE: the stack array has no reset; an entry is only meaningful once the pointer has covered it.
    always_ff @(posedge clock) begin
        if (push) stack[push_idx] <= push_data;
    end

`ifdef MICRO_SEQUENCER_STACK_GUARD_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stackOverflow  <= 1'b0;
            stackUnderflow <= 1'b0;
        end else begin
            if (set_overflow)  stackOverflow  <= 1'b1;
            if (set_underflow) stackUnderflow <= 1'b1;
        end
    end
    assign faulted = (state == ST_FAULT);
`else
    assign stackOverflow  = 1'b0;
    assign stackUnderflow = 1'b0;
    assign faulted        = 1'b0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed scoreboard bench for micro_sequencer (WAIT_TIMEOUT=4, STACK_DEPTH=4);
// follows MICRO_SEQUENCER_STACK_GUARD_EN to pick the guarded or wrapping stack scenario.
module tb_micro_sequencer;

    localparam logic [2:0] OP_NEXT     = 3'd0;
    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_BRANCH   = 3'd2;
    localparam logic [2:0] OP_CALL     = 3'd3;
    localparam logic [2:0] OP_RETURN   = 3'd4;
    localparam logic [2:0] OP_DISPATCH = 3'd5;
    localparam logic [2:0] OP_WAIT     = 3'd6;
    localparam logic [2:0] OP_FETCH    = 3'd7;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_INC   = 2'd1;
    localparam logic [1:0] CMD_RESET = 2'd2;
    localparam logic [1:0] CMD_LOAD  = 2'd3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] sequence_op = OP_NEXT;
    logic [7:0] target = '0;
    logic       condition = 1'b0;
    logic [7:0] dispatchAddress = '0;
    logic       ready = 1'b1;
    logic [7:0] address = '0;
    logic [1:0] command;
    logic [7:0] loadAddress;
    logic       timedOut, stackOverflow, stackUnderflow, faulted;

    typedef struct {
        string      tag;
        logic [1:0] cmd;
        logic [7:0] load;
        logic       to;
        logic       ovf;
        logic       unf;
        logic       flt;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic rst_v = 1'b1, cond_v = 1'b0;
    logic [7:0] disp_v = '0;
    logic exp_ovf = 1'b0, exp_unf = 1'b0, exp_flt = 1'b0;

    micro_sequencer #(
        .ADDRESS_WIDTH(8),
        .STACK_DEPTH  (4),
        .WAIT_TIMEOUT (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .sequence_op    (sequence_op),
        .target         (target),
        .condition      (condition),
        .dispatchAddress(dispatchAddress),
        .ready          (ready),
        .address        (address),
        .command        (command),
        .loadAddress    (loadAddress),
        .timedOut       (timedOut),
        .stackOverflow  (stackOverflow),
        .stackUnderflow (stackUnderflow),
        .faulted        (faulted)
    );

    always #5 clock = ~clock;

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty observed=0 entries expected=1");
            return;
        end
        e = sb.pop_front();
        vectors++;
        assert (command === e.cmd) else begin
            miscompares++;
            $error("FAIL %s command observed=%0d expected=%0d", e.tag, command, e.cmd);
        end
        vectors++;
        assert (loadAddress === e.load) else begin
            miscompares++;
            $error("FAIL %s loadAddress observed=%h expected=%h", e.tag, loadAddress, e.load);
        end
        vectors++;
        assert (timedOut === e.to) else begin
            miscompares++;
            $error("FAIL %s timedOut observed=%b expected=%b", e.tag, timedOut, e.to);
        end
        vectors++;
        assert ({stackOverflow, stackUnderflow, faulted} === {e.ovf, e.unf, e.flt}) else begin
            miscompares++;
            $error("FAIL %s flags(ovf,unf,flt) observed=%b%b%b expected=%b%b%b", e.tag,
                   stackOverflow, stackUnderflow, faulted, e.ovf, e.unf, e.flt);
        end
    endtask

    // Drive one microinstruction on the falling edge, queue its expectation, sample 2 ns later.
    task automatic step(input string tag, input logic [2:0] op, input logic [7:0] tgt,
                        input logic [7:0] addr, input logic rdy, input logic [1:0] ecmd,
                        input logic [7:0] eload, input logic eto);
        @(negedge clock);
        reset           = rst_v;
        condition       = cond_v;
        dispatchAddress = disp_v;
        sequence_op     = op;
        target          = tgt;
        address         = addr;
        ready           = rdy;
        sb.push_back('{tag, ecmd, eload, eto, exp_ovf, exp_unf, exp_flt});
        #2;
        compare_out();
    endtask

    initial begin
        rst_v = 1'b1;
        step("in_reset", OP_NEXT, 8'h00, 8'h10, 1'b1, CMD_RESET, 8'h00, 1'b0);
        rst_v = 1'b0;
        step("next", OP_NEXT, 8'h00, 8'h10, 1'b1, CMD_INC, 8'h00, 1'b0);
        step("jump", OP_JUMP, 8'h55, 8'h11, 1'b1, CMD_LOAD, 8'h55, 1'b0);
        cond_v = 1'b1;
        step("branch_taken", OP_BRANCH, 8'h40, 8'h12, 1'b1, CMD_LOAD, 8'h40, 1'b0);
        cond_v = 1'b0;
        step("branch_not", OP_BRANCH, 8'h40, 8'h13, 1'b1, CMD_INC, 8'h00, 1'b0);
        disp_v = 8'h9A;
        step("dispatch", OP_DISPATCH, 8'h00, 8'h14, 1'b1, CMD_LOAD, 8'h9A, 1'b0);
        step("call", OP_CALL, 8'h80, 8'h21, 1'b1, CMD_LOAD, 8'h80, 1'b0);
        step("return", OP_RETURN, 8'h00, 8'h85, 1'b1, CMD_LOAD, 8'h22, 1'b0);
        step("call_wrap", OP_CALL, 8'h10, 8'hFF, 1'b1, CMD_LOAD, 8'h10, 1'b0);
        step("return_wrap", OP_RETURN, 8'h00, 8'h10, 1'b1, CMD_LOAD, 8'h00, 1'b0);
        step("wait_ready", OP_WAIT, 8'h30, 8'h20, 1'b1, CMD_INC, 8'h00, 1'b0);

        // ready held low: four none cycles, load of the handler on the fifth; op input ignored meanwhile
        step("wait_enter", OP_WAIT, 8'h30, 8'h21, 1'b0, CMD_NONE, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++)
            step("wait_hold", OP_JUMP, 8'h30, 8'h22, 1'b0, CMD_NONE, 8'h00, 1'b0);
        step("wait_timeout", OP_JUMP, 8'h30, 8'h22, 1'b0, CMD_LOAD, 8'h30, 1'b1);
        step("after_timeout", OP_NEXT, 8'h30, 8'h30, 1'b0, CMD_INC, 8'h00, 1'b0);

        step("wait2_enter", OP_WAIT, 8'h30, 8'h23, 1'b0, CMD_NONE, 8'h00, 1'b0);
        step("wait2_hold", OP_JUMP, 8'h30, 8'h23, 1'b0, CMD_NONE, 8'h00, 1'b0);
        step("wait2_ready", OP_JUMP, 8'h30, 8'h23, 1'b1, CMD_INC, 8'h00, 1'b0);
        step("wait2_run", OP_JUMP, 8'h31, 8'h24, 1'b1, CMD_LOAD, 8'h31, 1'b0);

        step("wait3_enter", OP_WAIT, 8'h30, 8'h25, 1'b0, CMD_NONE, 8'h00, 1'b0);
        step("wait3_hold", OP_JUMP, 8'h30, 8'h25, 1'b0, CMD_NONE, 8'h00, 1'b0);
        rst_v = 1'b1;
        step("wait_reset", OP_JUMP, 8'h30, 8'h25, 1'b0, CMD_RESET, 8'h00, 1'b0);
        rst_v = 1'b0;
        step("post_reset", OP_JUMP, 8'h33, 8'h00, 1'b0, CMD_LOAD, 8'h33, 1'b0);
        step("fetch", OP_FETCH, 8'h30, 8'h40, 1'b1, CMD_RESET, 8'h00, 1'b0);

`ifdef MICRO_SEQUENCER_STACK_GUARD_EN
        step("g_call", OP_CALL, 8'h50, 8'h40, 1'b1, CMD_LOAD, 8'h50, 1'b0);
        step("g_fetch", OP_FETCH, 8'h00, 8'h50, 1'b1, CMD_RESET, 8'h00, 1'b0);
        step("g_underflow", OP_RETURN, 8'h00, 8'h00, 1'b1, CMD_NONE, 8'h00, 1'b0);
        exp_unf = 1'b1;
        exp_flt = 1'b1;
        step("g_unf_hold", OP_NEXT, 8'h00, 8'h00, 1'b1, CMD_NONE, 8'h00, 1'b0);
        step("g_unf_jump", OP_JUMP, 8'h70, 8'h00, 1'b1, CMD_NONE, 8'h00, 1'b0);
        rst_v = 1'b1;
        exp_unf = 1'b0;
        exp_flt = 1'b0;
        step("g_reset1", OP_NEXT, 8'h00, 8'h00, 1'b1, CMD_RESET, 8'h00, 1'b0);
        rst_v = 1'b0;
        step("g_run1", OP_NEXT, 8'h00, 8'h00, 1'b1, CMD_INC, 8'h00, 1'b0);

        for (int i = 0; i < 4; i++)
            step("g_call_n", OP_CALL, 8'h60, 8'(i), 1'b1, CMD_LOAD, 8'h60, 1'b0);
        step("g_overflow", OP_CALL, 8'h60, 8'h04, 1'b1, CMD_NONE, 8'h00, 1'b0);
        exp_ovf = 1'b1;
        exp_flt = 1'b1;
        step("g_ovf_return", OP_RETURN, 8'h00, 8'h60, 1'b1, CMD_NONE, 8'h00, 1'b0);
        step("g_ovf_next", OP_NEXT, 8'h00, 8'h60, 1'b1, CMD_NONE, 8'h00, 1'b0);
        rst_v = 1'b1;
        exp_ovf = 1'b0;
        exp_flt = 1'b0;
        step("g_reset2", OP_NEXT, 8'h00, 8'h00, 1'b1, CMD_RESET, 8'h00, 1'b0);
        rst_v = 1'b0;
        step("g_run2", OP_NEXT, 8'h00, 8'h00, 1'b1, CMD_INC, 8'h00, 1'b0);
        step("g_empty_return", OP_RETURN, 8'h00, 8'h01, 1'b1, CMD_NONE, 8'h00, 1'b0);
        exp_unf = 1'b1;
        exp_flt = 1'b1;
        step("g_empty_fault", OP_NEXT, 8'h00, 8'h01, 1'b1, CMD_NONE, 8'h00, 1'b0);
`else
        // five pushes of 1..5 into four slots: the oldest is overwritten, pops come back 5,4,3,2
        for (int i = 0; i < 5; i++)
            step("u_call", OP_CALL, 8'h60, 8'(i), 1'b1, CMD_LOAD, 8'h60, 1'b0);
        for (int k = 5; k >= 2; k--)
            step("u_return", OP_RETURN, 8'h00, 8'h61, 1'b1, CMD_LOAD, 8'(k), 1'b0);
        step("u_return_wrap", OP_RETURN, 8'h00, 8'h61, 1'b1, CMD_LOAD, 8'h05, 1'b0);
        step("u_next", OP_NEXT, 8'h00, 8'h61, 1'b1, CMD_INC, 8'h00, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Control-store sequencer for the microcode address counter. Each cycle it decodes the sequencing field of the current microinstruction and emits the counter's `command` and `loadAddress`: step, jump, conditional branch, opcode dispatch, subroutine call/return through a return-address stack, and ready-wait with timeout. It sits between the microinstruction register and the micro address counter, and consumes the counter's current `address`.

## Interface
- `ADDRESS_WIDTH`, 8: width of micro addresses.
- `STACK_DEPTH`, 4: number of return-address entries; power of two, ≥2.
- `WAIT_TIMEOUT`, 255: ready-low cycles before a WAIT times out; range 1..255.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sequence`  in  3  op: 0 NEXT, 1 JUMP, 2 BRANCH, 3 CALL, 4 RETURN, 5 DISPATCH, 6 WAIT, 7 FETCH.
- `target`  in  ADDRESS_WIDTH  jump/branch/call destination; timeout handler for WAIT.
- `condition`  in  1  branch condition, selected by the datapath.
- `dispatchAddress`  in  ADDRESS_WIDTH  opcode-mapped entry address.
- `ready`  in  1  external unit done, sampled during WAIT.
- `address`  in  ADDRESS_WIDTH  current counter address.
- `command`  out  2  counter command: 0 none, 1 increment, 2 reset, 3 load.
- `loadAddress`  out  ADDRESS_WIDTH  valid when `command`=3, else 0.
- `timedOut`  out  1  high in the cycle a WAIT timeout load is issued.
- `stackOverflow`, `stackUnderflow`  out  1  sticky fault flags.
- `faulted`  out  1  high while in FAULT.

## Operation
- States: RUN, WAITING, FAULT. Reset sets RUN, stack pointer 0, waitCount 0 and both flags 0.
- `command`/`loadAddress`/`timedOut` are combinational from state, inputs and stack. State, stack and counters update on the rising edge of `clock`.
- Behaviour in RUN:
  - NEXT → increment.
  - JUMP → load `target`.
  - BRANCH → load `target` if `condition`, else increment.
  - DISPATCH → load `dispatchAddress`.
  - CALL → push `address`+1 (mod 2^ADDRESS_WIDTH), then load `target`.
  - RETURN → pop, then load the popped value.
  - FETCH → reset (command 2); clears the stack pointer to 0; stay in RUN.
  - WAIT with `ready`=1 → increment. WAIT with `ready`=0 → none; set waitCount=1; go to WAITING.
- WAITING (the `sequence` input is ignored):
  - `ready`=1 → increment; go to RUN.
  - `ready`=0 and waitCount==WAIT_TIMEOUT → load `target`; `timedOut`=1; go to RUN.
  - Otherwise → none; waitCount+1.
- FAULT: command none; leaves only on `reset`.
- Stack is LIFO with occupancy 0..STACK_DEPTH. A CALL at full is an overflow; a RETURN at empty is an underflow. Fault handling is set by the guard macro.

## Timing
- Zero-cycle decode: the command applies at the same edge the counter samples it, so the counter address changes one edge after the instruction is presented.
- A push or pop commits at the edge; a RETURN immediately after a CALL sees the pushed value.
- WAIT with `ready` always low issues WAIT_TIMEOUT none cycles, then the load on cycle WAIT_TIMEOUT+1.
- `reset` asserted mid-WAITING or in FAULT returns immediately and asynchronously to the reset state. While `reset` is high, `command`=2 and `loadAddress`=0.

## Configuration
- `MICRO_SEQUENCER_STACK_GUARD_EN` defined:
  - Overflow sets `stackOverflow`, enters FAULT and issues none; no push is done.
  - Underflow sets `stackUnderflow` and enters FAULT likewise.
- Undefined:
  - Pointer wraps modulo STACK_DEPTH. A push at full overwrites the oldest entry.
  - A pop at empty returns the entry at (pointer−1) mod STACK_DEPTH.
  - Flags and `faulted` are tied to 0; FAULT is unreachable.

## Test plan
- Reset, then NEXT at `address`=0x10 → `command`=1, `loadAddress`=0. During reset → `command`=2.
- BRANCH with `target`=0x40: `condition`=1 → command 3, load 0x40. `condition`=0 → command 1.
- CALL `target`=0x80 at `address`=0x21, then RETURN at 0x85 → load 0x80, then load 0x22. CALL at `address`=0xFF pushes 0x00.
- WAIT_TIMEOUT=4, WAIT `target`=0x30, `ready` held low → 4 cycles of command 0, then command 3 / 0x30 with `timedOut`=1. Repeat with `ready` rising on cycle 3 → increment, no timeout.
- Guard on, STACK_DEPTH=4: 5 CALLs → 5th gives `stackOverflow`=1, `faulted`=1, command 0 until reset. RETURN on an empty stack → `stackUnderflow`=1.
- Guard off: 5 CALLs pushing 1..5, then 4 RETURNs → loads 5, 4, 3, 2; flags stay 0.
